// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// maverickOne_pkg : core-wide constants shared by the front end.
//
// fetch_pc_unit : instruction-fetch front end sitting directly upstream of
// the branch target buffer.
//   - Owns the architectural fetch PC (pc_q) and presents it to the BTB.
//   - Steers fetch with the BTB's hit/flush/target signals.
//   - Issues one request at a time to instruction memory.
//   - Buffers returned instructions, tagged with their PC and a
//     predicted-taken flag, in a small FIFO toward decode.
//
// Ports:
//   clk_i, arst_i               clock; asynchronous active-high reset
//   pc_o                        current fetch PC (to BTB pc_i)
//   match_found_i               BTB hit for pc_o
//   flush_i, next_pc_i          BTB flush/redirect and target PC
//   imem_req_valid_o/ready_i    instruction memory request handshake
//   imem_req_addr_o             request address (same as pc_o)
//   imem_rsp_valid_i/data_i     in-order response, one per accepted request
//   instr_valid_o/ready_i       decode-side handshake
//   instr_o, instr_pc_o,        FIFO head: instruction, its PC and whether
//   instr_pred_taken_o          it was fetched under a BTB hit
// ---------------------------------------------------------------------------
package maverickOne_pkg;
  localparam int unsigned XLEN = 32;
endpackage

module fetch_pc_unit #(
  parameter int unsigned           XLEN       = maverickOne_pkg::XLEN,
  parameter logic [XLEN-1:0]       RESET_ADDR = '0,
  parameter int unsigned           FQ_DEPTH   = 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  output logic [XLEN-1:0] pc_o,
  input  logic            match_found_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] next_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_pred_taken_o
);

  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

  // WAIT: a response is owed and will be kept.
  // DROP: a response is owed but belongs to a flushed path.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            pt_q;

  logic [31:0]     data_mem [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
  logic            pt_mem   [FQ_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   fifo_count;

  logic            outstanding;
  logic            space;
  logic            handshake;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  // BTB targets are word aligned by force; low bits of next_pc_i are ignored.
  assign target = {next_pc_i[XLEN-1:2], 2'b00};

  // A request is only issued if its response is guaranteed a FIFO slot, so
  // the outstanding response counts against capacity.
  assign outstanding = (state != S_REQ);
  assign space       = ({1'b0, fifo_count} + {{CW{1'b0}}, outstanding})
                       < (CW+1)'(FQ_DEPTH);

  assign pc_o             = pc_q;
  assign imem_req_addr_o  = pc_q;
  assign imem_req_valid_o = ~arst_i & (state == S_REQ) & space & ~flush_i;
  assign handshake        = imem_req_valid_o & imem_req_ready_i;

  // Flush kills both the incoming response and any same-cycle pop.
  assign push = (state == S_WAIT) & imem_rsp_valid_i & ~flush_i;

  assign instr_valid_o      = (fifo_count != '0);
  assign pop                = instr_valid_o & instr_ready_i & ~flush_i;
  assign instr_o            = data_mem[rd_ptr];
  assign instr_pc_o         = pc_mem[rd_ptr];
  assign instr_pred_taken_o = pt_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register regardless of order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= S_REQ;
      pc_q       <= RESET_ADDR;
      req_pc_q   <= RESET_ADDR;
      pt_q       <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush_i) begin
      pc_q       <= target;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      unique case (state)
        S_WAIT:  state <= imem_rsp_valid_i ? S_REQ : S_DROP;
        S_DROP:  state <= imem_rsp_valid_i ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (handshake) begin
            pt_q     <= match_found_i;
            req_pc_q <= pc_q;
            pc_q     <= match_found_i ? target : pc_q + XLEN'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid_i) state <= S_REQ;
        S_DROP:  if (imem_rsp_valid_i) state <= S_REQ;
        default: state <= S_REQ;
      endcase
      // Depth is a power of two, so pointers wrap on their own.
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the FIFO storage has no reset; validity is tracked entirely by
  // fifo_count, and leaving the array unreset lets it map onto plain flops
  // or a register file without a reset tree.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data_i;
      pc_mem[wr_ptr]   <= req_pc_q;
      pt_mem[wr_ptr]   <= pt_q;
    end
  end

endmodule
